// File: rtl/fpga_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared definitions for the LUT-fabric configuration loader:
//   - FSM state encodings (legacy-compatible localparam constants)
//   - configuration byte width
//   - checksum accumulation helper (running XOR reduce)
// -----------------------------------------------------------------------------
package fpga_cfg_pkg;

    localparam int BYTE_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // One step of the XOR-reduce checksum over the bitstream bytes.
    function automatic logic [BYTE_W-1:0] cksum_accum(
        input logic [BYTE_W-1:0] acc,
        input logic [BYTE_W-1:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cfg_timeout_ctr.sv
// -----------------------------------------------------------------------------
// cfg_timeout_ctr
// Loadable down-counter that flags a stalled bitstream source.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset (counter cleared)
//   load    in  reload to TIMEOUT-1 (LOAD entry or accepted byte)
//   run     in  count enable (loader is waiting for bytes)
//   expired out run && counter exhausted; the edge on which this is seen is
//               the TIMEOUT-th consecutive edge without an accepted byte
// -----------------------------------------------------------------------------
module cfg_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // After a reload, edges 1..TIMEOUT-1 decrement; edge TIMEOUT sees zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// fpga_cfg_loader
// Configuration controller for the LUT fabric. Accepts a byte-wide bitstream
// over valid/ready, writes each of NUM_WORDS bytes into the fabric
// configuration store, verifies a trailing XOR checksum and then releases the
// fabric through fabric_en.
// Ports:
//   clk, reset          clock / asynchronous active-high reset
//   start, abort        one-cycle control pulses
//   bs_data, bs_valid   bitstream byte and its valid
//   bs_ready            loader can accept a byte (registered)
//   cfg_we/addr/data    one-cycle write into the configuration store
//   cfg_done            bitstream loaded and checksum matched
//   cfg_error           checksum mismatch or source timeout
//   fabric_en           fabric may operate; mirrors cfg_done
// All outputs are registered.
// -----------------------------------------------------------------------------
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [BYTE_W-1:0] cfg_data,
    output logic              cfg_done,
    output logic              cfg_error,
    output logic              fabric_en
);

    // Counter is one bit wider than the address so NUM_WORDS == 2**ADDR_W fits.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_WORDS - 1);

    logic [2:0]        state;
    logic [ADDR_W:0]   byte_cnt;
    logic [BYTE_W-1:0] run_xor;

    logic accept;
    logic in_run;
    logic entry;
    logic to_load;
    logic to_expired;

    assign accept  = bs_valid && bs_ready;
    assign in_run  = (state == ST_LOAD) || (state == ST_CHECK);
    // start is honoured only outside an active load; abort never blocks it there.
    assign entry   = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign to_load = entry || (in_run && accept);

    cfg_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (to_load),
        .run     (in_run),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            run_xor   <= '0;
            bs_ready  <= 1'b0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            fabric_en <= 1'b0;
        end else begin
            cfg_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (entry) begin
                        state     <= ST_LOAD;
                        byte_cnt  <= '0;
                        run_xor   <= '0;
                        cfg_addr  <= '0;
                        bs_ready  <= 1'b1;
                        cfg_done  <= 1'b0;
                        fabric_en <= 1'b0;
                        cfg_error <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        // A byte accepted on this edge is dropped.
                        state    <= ST_IDLE;
                        bs_ready <= 1'b0;
                    end else if (accept) begin
                        cfg_we   <= 1'b1;
                        cfg_addr <= byte_cnt[ADDR_W-1:0];
                        cfg_data <= bs_data;
                        run_xor  <= cksum_accum(run_xor, bs_data);
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_IDX) begin
                            state <= ST_CHECK;
                        end
                    end else if (to_expired) begin
                        state     <= ST_ERR;
                        bs_ready  <= 1'b0;
                        cfg_error <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        bs_ready <= 1'b0;
                    end else if (accept) begin
                        // The checksum byte is compared only, never written.
                        bs_ready <= 1'b0;
                        if (bs_data == run_xor) begin
                            state     <= ST_DONE;
                            cfg_done  <= 1'b1;
                            fabric_en <= 1'b1;
                        end else begin
                            state     <= ST_ERR;
                            cfg_error <= 1'b1;
                        end
                    end else if (to_expired) begin
                        state     <= ST_ERR;
                        bs_ready  <= 1'b0;
                        cfg_error <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bs_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_fpga_cfg_loader
// Self-checking bench for fpga_cfg_loader. Expected writes and the expected
// checksum verdict are derived from the bitstream contents held in the bench.
// -----------------------------------------------------------------------------
module tb_fpga_cfg_loader;

    localparam int NW = 16;
    localparam int AW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    bs_data = 8'h00;
    logic          bs_valid = 1'b0;
    logic          bs_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_data;
    logic          cfg_done;
    logic          cfg_error;
    logic          fabric_en;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]    blk [NW];
    logic [AW-1:0] wa_q [$];
    logic [7:0]    wd_q [$];

    fpga_cfg_loader #(
        .NUM_WORDS (NW),
        .ADDR_W    (AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .bs_data   (bs_data),
        .bs_valid  (bs_valid),
        .bs_ready  (bs_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .fabric_en (fabric_en)
    );

    always #5 clk = ~clk;

    // Record every store write just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (cfg_we) begin
            wa_q.push_back(cfg_addr);
            wd_q.push_back(cfg_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_cksum();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < NW; i++) x = x ^ blk[i];
        return x;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NW; i++) blk[i] = 8'($urandom);
    endtask

    task automatic start_load();
        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_rdy", bs_ready, 1);
        chk("start_flags", {cfg_done, fabric_en, cfg_error}, 0);
        chk("start_addr", cfg_addr, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bs_valid = 1'b0;
            @(negedge clk);
            chk("gap_we", cfg_we, 0);
        end
        bs_valid = 1'b1;
        bs_data  = b;
        for (int w = 0; w < 2 * TO && !acc; w++) begin
            acc = bs_ready;
            @(negedge clk);
        end
        bs_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic check_writes(input int n);
        chk("n_writes", wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            chk("wr_addr", wa_q[i], i);
            chk("wr_data", wd_q[i], blk[i]);
        end
    endtask

    task automatic run_full(input logic [7:0] ck, input int min_gap, input int max_gap);
        bit ok;
        ok = (ck == ref_cksum());
        start_load();
        for (int i = 0; i < NW; i++) send_byte(blk[i], $urandom_range(max_gap, min_gap));
        send_byte(ck, $urandom_range(max_gap, min_gap));
        chk("fin_done", cfg_done, ok);
        chk("fin_fabric_en", fabric_en, ok);
        chk("fin_error", cfg_error, !ok);
        chk("fin_rdy", bs_ready, 0);
        chk("fin_we", cfg_we, 0);
        @(negedge clk);
        check_writes(NW);
    endtask

    initial begin
        int n;
        // Reset state, asserted before the first clock edge.
        #3;
        chk("rst_outputs", {bs_ready, cfg_we, cfg_addr, cfg_data, cfg_done, cfg_error, fabric_en}, 0);
        @(negedge clk);
        reset = 1'b0;
        // Abort in IDLE is ignored and nothing is accepted.
        abort = 1'b1;
        bs_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bs_valid = 1'b0;
        chk("idle_rdy", bs_ready, 0);
        chk("idle_we", cfg_we, 0);

        // Happy path: 0x00..0x0F, checksum 0x00.
        for (int i = 0; i < NW; i++) blk[i] = 8'(i);
        run_full(8'h00, 0, 0);
        // Bad checksum.
        run_full(8'h01, 0, 0);
        // 5-cycle gaps between every byte.
        run_full(8'h00, 5, 5);

        // Randomised bitstreams, gaps and checksum corruption.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] ck;
            fill_random();
            ck = ref_cksum();
            if ($urandom_range(1, 0) == 1) ck = ck ^ (8'h01 << $urandom_range(7, 0));
            run_full(ck, 0, 3);
        end

        // Timeout: three bytes then silence.
        fill_random();
        start_load();
        for (int i = 0; i < 3; i++) send_byte(blk[i], $urandom_range(2, 0));
        n = 0;
        while (!cfg_error && n < 2 * TO) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_flags", {cfg_done, fabric_en, bs_ready}, 0);
        check_writes(3);

        // Start ignored during LOAD, abort after byte 7 (with a byte on the abort edge).
        fill_random();
        start_load();
        for (int i = 0; i < 3; i++) send_byte(blk[i], 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ign_rdy", bs_ready, 1);
        for (int i = 3; i < 7; i++) send_byte(blk[i], 1);
        abort = 1'b1;
        bs_valid = 1'b1;
        bs_data = 8'hAA;
        @(negedge clk);
        abort = 1'b0;
        bs_valid = 1'b0;
        chk("abort_rdy", bs_ready, 0);
        chk("abort_we", cfg_we, 0);
        chk("abort_flags", {cfg_done, cfg_error, fabric_en}, 0);
        @(negedge clk);
        chk("abort_idle_rdy", bs_ready, 0);
        check_writes(7);
        fill_random();
        run_full(ref_cksum(), 0, 2);

        // Asynchronous reset between edges after byte 10.
        fill_random();
        start_load();
        for (int i = 0; i < 10; i++) send_byte(blk[i], 0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_outputs", {bs_ready, cfg_we, cfg_addr, cfg_data, cfg_done, cfg_error, fabric_en}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fill_random();
        run_full(ref_cksum(), 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Configuration controller for the LUT fabric.
- Accepts a byte-wide bitstream over a valid/ready handshake and writes it word-by-word into the fabric's configuration store.
- Verifies a trailing XOR checksum, then releases the fabric for operation via fabric_en.
- Sits between the host/bitstream source and the fabric's configuration port. It replaces driving a static bitfile_input directly.

Parameters:
- NUM_WORDS, 16, number of configuration bytes per bitstream (excluding checksum); must be ≥2.
- ADDR_W, 4, width of cfg_addr; must satisfy 2**ADDR_W ≥ NUM_WORDS.
- TIMEOUT, 64, max idle cycles between accepted bytes in LOAD/CHECK before error; must be ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a configuration load.
- abort  in  1  one-cycle pulse; cancels an in-progress load.
- bs_data  in  8  bitstream byte.
- bs_valid  in  1  bs_data valid.
- bs_ready  out  1  loader can accept a byte.
- cfg_we  out  1  write strobe to the fabric configuration store.
- cfg_addr  out  ADDR_W  configuration word address.
- cfg_data  out  8  configuration word.
- cfg_done  out  1  configuration loaded and checksum matched.
- cfg_error  out  1  checksum mismatch or timeout.
- fabric_en  out  1  fabric may consume In_1/In_2; equals cfg_done.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, all outputs 0, byte counter=0, running XOR=0, timeout counter=0. Reset asserted mid-load takes effect immediately. Fabric store contents are then don't-care, and cfg_done stays 0 until a full successful reload.
- All outputs are registered.
- Handshake: a byte is accepted on a rising edge where bs_valid && bs_ready. bs_data is sampled only on acceptance. The source may deassert bs_valid at any time; bs_ready never depends combinationally on bs_valid.
- States:
  - IDLE: bs_ready=0. start → LOAD, clear counter and XOR. abort ignored.
  - LOAD: bs_ready=1.
    - Each accepted byte: register cfg_we=1, cfg_addr=counter, cfg_data=byte on the next cycle, for exactly one cycle. Also XOR the byte into the running XOR and increment the counter.
    - When the NUM_WORDS-th byte is accepted → CHECK.
  - CHECK: bs_ready=1. The accepted byte is compared with the running XOR; it is never written to the store.
    - Match → DONE.
    - Mismatch → ERR.
  - DONE: bs_ready=0, cfg_done=1, fabric_en=1. start → LOAD; cfg_done and fabric_en drop on the same cycle the state enters LOAD.
  - ERR: bs_ready=0, cfg_error=1. start → LOAD; cfg_error clears on LOAD entry.
- Timeout:
  - The counter runs in LOAD/CHECK and resets on every accepted byte.
  - Reaching TIMEOUT consecutive cycles without acceptance → ERR.
  - Acceptance on the same edge as expiry wins: the byte is accepted and there is no error.
- Abort in LOAD/CHECK → IDLE next cycle, bs_ready=0. A byte accepted on the abort edge is discarded with no cfg_we. Done/error flags remain 0.
- start in LOAD/CHECK is ignored.
- start and abort both high in IDLE/DONE/ERR: start wins. In LOAD/CHECK: abort wins.
- Latency:
  - start → bs_ready high is 1 cycle.
  - Last (checksum) byte accepted → cfg_done/cfg_error high is 1 cycle.
- cfg_addr wraps to 0 on every LOAD entry. Counter width is ADDR_W+1, so no overflow occurs at NUM_WORDS=2**ADDR_W.

Decomposition:
- Shared package fpga_cfg_pkg holds:
  - state enum/localparams (IDLE, LOAD, CHECK, DONE, ERR);
  - the byte-width constant (8);
  - the checksum function (XOR reduce).
- One sub-module is natural: cfg_timeout_ctr, a loadable down-counter with clear and expiry flag. Everything else stays in fpga_cfg_loader.

Test Plan:
- Happy path: reset, start, stream 0x00..0x0F back-to-back, then checksum 0x00.
  - 16 cfg_we pulses at addr 0..15 with data = addr.
  - bs_ready low and cfg_done=fabric_en=1 one cycle after the checksum is accepted.
- Bad checksum: same data with checksum 0x01 → cfg_error=1, cfg_done=0, no 17th cfg_we.
- Backpressure/gaps: insert 5-cycle bs_valid gaps between every byte of the valid stream → identical writes and final cfg_done=1; cfg_we never asserts during gaps.
- Timeout: after 3 bytes, hold bs_valid low → cfg_error=1 exactly TIMEOUT cycles after the 3rd acceptance.
- Abort and start-ignore:
  - start pulsed during LOAD → no effect.
  - abort after byte 7 → IDLE and bs_ready=0; a following start reloads from addr 0 and completes with cfg_done=1.
- Reset mid-load: assert reset asynchronously between edges after byte 10 → all outputs 0 immediately; a reload afterwards succeeds with cfg_done=1.
